// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_pkg;

    localparam int          INSTR_W          = 32;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0040_0000;
    localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;

    typedef enum logic [1:0] {
        S_BOOT     = 2'd0,
        S_RUN      = 2'd1,
        S_REDIRECT = 2'd2
    } fetchState_t;

    // One skid-buffer entry: the fetched word and the address it came from.
    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [31:0]        pc;
    } fetchEntry_t;

    // Redirect targets are forced onto a word boundary.
    function automatic logic [31:0] alignPc(input logic [31:0] pc);
        return {pc[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Bus between the fetch stage, the instruction ROM, IF/ID and the redirect sources.
//
// Handshake: an IF/ID entry transfers at a rising edge when if_valid=1 and
// stall=0; while stall=1 the head entry and every if_* output hold steady.
// The ROM has no backpressure: a word requested with imem_en=1 at imem_addr
// comes back on imem_rdata in the following cycle. redirect_valid is a
// single-cycle command that is always accepted.
interface fetch_stage_if;
    import fetch_pkg::*;

    logic               stall;
    logic               redirect_valid;
    logic [31:0]        redirect_pc;
    logic               imem_en;
    logic [31:0]        imem_addr;
    logic [INSTR_W-1:0] imem_rdata;
    logic               if_valid;
    logic [INSTR_W-1:0] if_instruction;
    logic [31:0]        if_pc;
    logic [31:0]        if_pc_4;
    logic               misalign_err;

    // Fetch-stage side.
    modport master (
        input  stall, redirect_valid, redirect_pc, imem_rdata,
        output imem_en, imem_addr, if_valid, if_instruction, if_pc, if_pc_4, misalign_err
    );

    // Environment side: ROM, hazard unit, IF/ID and branch resolution.
    modport slave (
        output stall, redirect_valid, redirect_pc, imem_rdata,
        input  imem_en, imem_addr, if_valid, if_instruction, if_pc, if_pc_4, misalign_err
    );

endinterface

// File: rtl/fetch_skid_fifo.sv
// Two-entry skid buffer holding {instr, pc} words returned by the ROM.
module fetch_skid_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        push,
    input  logic        pop,
    input  logic        flush,
    input  fetchEntry_t dataIn,
    output fetchEntry_t dataOut,
    output logic        full,
    output logic        empty,
    output logic [1:0]  count
);

    fetchEntry_t mem [2];
    logic        wrPtr;
    logic        rdPtr;
    logic [1:0]  countQ;

    // Pointers and occupancy; flush empties the buffer in one cycle.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wrPtr  <= 1'b0;
            rdPtr  <= 1'b0;
            countQ <= 2'd0;
        end else begin
            if (push) wrPtr <= ~wrPtr;
            if (pop)  rdPtr <= ~rdPtr;
            case ({push, pop})
                2'b10:   countQ <= countQ + 2'd1;
                2'b01:   countQ <= countQ - 2'd1;
                default: countQ <= countQ;
            endcase
        end
    end

    // Storage; a push on a full buffer with a pop reuses the slot being vacated.
    always_ff @(posedge clk) begin
        if (push && !flush && !reset) mem[wrPtr] <= dataIn;
    end

    // Popping an empty buffer means the caller's valid logic is broken.
    always_ff @(posedge clk) begin
        if (!reset && !flush) assert (!(pop && countQ == 2'd0));
    end

    assign dataOut = mem[rdPtr];
    assign full    = (countQ == 2'(DEPTH));
    assign empty   = (countQ == 2'd0);
    assign count   = countQ;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC, ROM request issue, redirect handling and the
// skid buffer feeding the IF/ID register.
module fetch_stage
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic          clk,
    input  logic          reset,
    fetch_stage_if.master bus,
    output fetchState_t   dbgState
);

    fetchState_t state;
    fetchState_t nextState;
    logic [31:0] fetchPc;
    logic [31:0] reqPc;
    logic        inflight;
    logic        misalignErr;
    logic        issue;
    logic        respValid;
    logic        headValid;
    logic        pop;
    logic        outValid;
    logic        fifoPush;
    logic        fifoPop;
    logic        fifoFull;
    logic        fifoEmpty;
    logic [1:0]  fifoCount;
    logic [2:0]  occupancy;
    fetchEntry_t respEntry;
    fetchEntry_t fifoHead;
    fetchEntry_t headEntry;

    // A response returning into S_REDIRECT belongs to the abandoned path.
    assign respValid = inflight && (state != S_REDIRECT);
    assign respEntry = '{instr: bus.imem_rdata, pc: reqPc};

    // With an empty buffer the returning word is presented directly (fall-through).
    assign headValid = !fifoEmpty || respValid;
    assign headEntry = fifoEmpty ? respEntry : fifoHead;
    assign pop       = headValid && !bus.stall;
    assign fifoPop   = pop && !fifoEmpty;
    assign fifoPush  = respValid && !(fifoEmpty && pop);

    // Words that will be held after this edge if a new request goes out now.
    assign occupancy = {1'b0, fifoCount} + {2'b00, inflight} - {2'b00, pop};

    fetch_skid_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) uSkidFifo (
        .clk     (clk),
        .reset   (reset),
        .push    (fifoPush),
        .pop     (fifoPop),
        .flush   (bus.redirect_valid),
        .dataIn  (respEntry),
        .dataOut (fifoHead),
        .full    (fifoFull),
        .empty   (fifoEmpty),
        .count   (fifoCount)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state <= S_BOOT;
        else       state <= nextState;
    end

    // Next-state logic: a redirect wins in every state.
    always_comb begin
        nextState = state;
        if (bus.redirect_valid) begin
            nextState = S_REDIRECT;
        end else begin
            case (state)
                S_BOOT:     nextState = S_RUN;
                S_RUN:      nextState = S_RUN;
                S_REDIRECT: nextState = S_RUN;
                default:    nextState = S_BOOT;
            endcase
        end
    end

    // Output logic: boot and redirect cycles always issue, run issues while room remains.
    always_comb begin
        issue = 1'b0;
        case (state)
            S_BOOT:     issue = 1'b1;
            S_REDIRECT: issue = 1'b1;
            S_RUN:      issue = (occupancy < 3'(FIFO_DEPTH));
            default:    issue = 1'b0;
        endcase
    end

    // PC, outstanding-request record and sticky misalignment flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            fetchPc     <= RESET_PC;
            reqPc       <= 32'h0;
            inflight    <= 1'b0;
            misalignErr <= 1'b0;
        end else begin
            inflight <= issue;
            if (issue) reqPc <= fetchPc;
            if (bus.redirect_valid)  fetchPc <= alignPc(bus.redirect_pc);
            else if (issue)          fetchPc <= fetchPc + 32'd4;
            if (bus.redirect_valid && (bus.redirect_pc[1:0] != 2'b00)) misalignErr <= 1'b1;
        end
    end

    // The issue rule must keep the skid buffer from overflowing.
    always_ff @(posedge clk) begin
        if (!reset && !bus.redirect_valid) assert (!(fifoPush && !fifoPop && fifoFull));
    end

    // Everything reads as idle while reset is held.
    assign outValid           = headValid && !reset;
    assign bus.if_valid       = outValid;
    assign bus.if_instruction = outValid ? headEntry.instr : NOP_INSTR;
    assign bus.if_pc          = outValid ? headEntry.pc : 32'h0;
    assign bus.if_pc_4        = outValid ? (headEntry.pc + 32'd4) : 32'h0;
    assign bus.imem_en        = issue && !reset;
    assign bus.imem_addr      = reset ? 32'h0 : fetchPc;
    assign bus.misalign_err   = misalignErr && !reset;
    assign dbgState           = state;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: boot, streaming, stall, redirect,
// misaligned target, wrap-around and mid-stall reset.
module tb_fetch_stage;
    import fetch_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    fetchState_t dbgState;
    int          passCount  = 0;
    int          checkCount = 0;
    int          failCount  = 0;

    fetch_stage_if bus ();

    fetch_stage dut (
        .clk      (clk),
        .reset    (reset),
        .bus      (bus),
        .dbgState (dbgState)
    );

    // Clock.
    always #5 clk = ~clk;

    // ROM contents: a recognisable word at the reset vector, address-derived elsewhere.
    function automatic logic [31:0] romWord(input logic [31:0] a);
        if (a == 32'h0040_0000) return 32'h2008_0005;
        return a ^ 32'hDEAD_0000;
    endfunction

    // Synchronous-read ROM with one cycle of latency.
    always @(posedge clk) begin
        if (bus.imem_en) bus.imem_rdata <= romWord(bus.imem_addr);
    end

    // Safety net in case the sequence ever stops advancing.
    initial begin
        #100000;
        $display("FAIL timeout: observed no summary by 100000 expected finish");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checkCount++;
        assert (obs === exp) passCount++;
        else begin
            failCount++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance to the next falling edge, apply inputs, let outputs settle.
    task automatic cycle(input logic r, input logic s, input logic rv, input logic [31:0] rp);
        @(negedge clk);
        reset              = r;
        bus.stall          = s;
        bus.redirect_valid = rv;
        bus.redirect_pc    = rp;
        #1;
    endtask

    task automatic checkOut(input string tag, input logic [31:0] pc);
        check({tag, "_valid"}, 32'(bus.if_valid), 32'd1);
        check({tag, "_pc"},    bus.if_pc, pc);
        check({tag, "_pc4"},   bus.if_pc_4, pc + 32'd4);
        check({tag, "_instr"}, bus.if_instruction, romWord(pc));
    endtask

    task automatic checkBubble(input string tag);
        check({tag, "_valid"}, 32'(bus.if_valid), 32'd0);
        check({tag, "_instr"}, bus.if_instruction, 32'h0);
    endtask

    task automatic checkIdle(input string tag);
        checkBubble(tag);
        check({tag, "_pc"},       bus.if_pc, 32'h0);
        check({tag, "_pc4"},      bus.if_pc_4, 32'h0);
        check({tag, "_en"},       32'(bus.imem_en), 32'd0);
        check({tag, "_misalign"}, 32'(bus.misalign_err), 32'd0);
    endtask

    task automatic resetAndBoot();
        cycle(1'b1, 1'b0, 1'b0, 32'h0);
        cycle(1'b1, 1'b0, 1'b0, 32'h0);
        cycle(1'b0, 1'b0, 1'b0, 32'h0);
        check("boot_state", 32'(dbgState), 32'(S_BOOT));
        check("boot_addr",  bus.imem_addr, 32'h0040_0000);
    endtask

    // Directed sequence.
    initial begin
        reset              = 1'b1;
        bus.stall          = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 32'h0;

        // Reset held: everything idle.
        cycle(1'b1, 1'b0, 1'b0, 32'h0);
        cycle(1'b1, 1'b0, 1'b0, 32'h0);
        checkIdle("reset_hold");

        // Boot cycle, then eight back-to-back words.
        cycle(1'b0, 1'b0, 1'b0, 32'h0);
        check("boot0_state", 32'(dbgState), 32'(S_BOOT));
        check("boot0_en",    32'(bus.imem_en), 32'd1);
        check("boot0_addr",  bus.imem_addr, 32'h0040_0000);
        checkBubble("boot0_out");
        for (int k = 0; k < 8; k++) begin
            cycle(1'b0, 1'b0, 1'b0, 32'h0);
            checkOut("stream", 32'h0040_0000 + 32'(4 * k));
            if (k == 0) check("first_instr", bus.if_instruction, 32'h2008_0005);
        end

        // Stall three cycles at 0x00400008.
        resetAndBoot();
        cycle(1'b0, 1'b0, 1'b0, 32'h0);
        checkOut("pre_stall0", 32'h0040_0000);
        cycle(1'b0, 1'b0, 1'b0, 32'h0);
        checkOut("pre_stall1", 32'h0040_0004);
        for (int s = 0; s < 3; s++) begin
            cycle(1'b0, 1'b1, 1'b0, 32'h0);
            checkOut("stall_hold", 32'h0040_0008);
            if (s > 0) check("stall_no_issue", 32'(bus.imem_en), 32'd0);
        end
        cycle(1'b0, 1'b0, 1'b0, 32'h0);
        checkOut("release0", 32'h0040_0008);
        check("release0_addr", bus.imem_addr, 32'h0040_0010);
        cycle(1'b0, 1'b0, 1'b0, 32'h0);
        checkOut("release1", 32'h0040_000C);
        cycle(1'b0, 1'b0, 1'b0, 32'h0);
        checkOut("release2", 32'h0040_0010);

        // Redirect while stalled with both skid entries full.
        resetAndBoot();
        cycle(1'b0, 1'b0, 1'b0, 32'h0);
        cycle(1'b0, 1'b0, 1'b0, 32'h0);
        cycle(1'b0, 1'b1, 1'b0, 32'h0);
        cycle(1'b0, 1'b1, 1'b0, 32'h0);
        cycle(1'b0, 1'b1, 1'b1, 32'h0040_0040);
        checkOut("redir_at", 32'h0040_0008);
        cycle(1'b0, 1'b0, 1'b0, 32'h0);
        checkBubble("redir_bubble");
        check("redir_state", 32'(dbgState), 32'(S_REDIRECT));
        check("redir_en",    32'(bus.imem_en), 32'd1);
        check("redir_addr",  bus.imem_addr, 32'h0040_0040);
        cycle(1'b0, 1'b0, 1'b0, 32'h0);
        checkOut("redir_tgt", 32'h0040_0040);
        cycle(1'b0, 1'b0, 1'b0, 32'h0);
        checkOut("redir_next", 32'h0040_0044);

        // Misaligned redirect target.
        cycle(1'b0, 1'b0, 1'b1, 32'h0040_0022);
        checkOut("mis_at", 32'h0040_0048);
        check("mis_before", 32'(bus.misalign_err), 32'd0);
        cycle(1'b0, 1'b0, 1'b0, 32'h0);
        checkBubble("mis_bubble");
        check("mis_addr", bus.imem_addr, 32'h0040_0020);
        check("mis_set",  32'(bus.misalign_err), 32'd1);
        cycle(1'b0, 1'b0, 1'b0, 32'h0);
        checkOut("mis_tgt", 32'h0040_0020);
        cycle(1'b0, 1'b0, 1'b0, 32'h0);
        checkOut("mis_next", 32'h0040_0024);
        check("mis_sticky", 32'(bus.misalign_err), 32'd1);

        // Back-to-back redirects, the second one landing on the last word of memory.
        cycle(1'b0, 1'b0, 1'b1, 32'h0040_0100);
        checkOut("rr_at", 32'h0040_0028);
        cycle(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC);
        checkBubble("rr_first");
        check("rr_first_addr", bus.imem_addr, 32'h0040_0100);
        cycle(1'b0, 1'b0, 1'b0, 32'h0);
        checkBubble("rr_second");
        check("rr_second_addr", bus.imem_addr, 32'hFFFF_FFFC);
        cycle(1'b0, 1'b0, 1'b0, 32'h0);
        checkOut("wrap_top", 32'hFFFF_FFFC);
        check("wrap_pc4", bus.if_pc_4, 32'h0000_0000);
        cycle(1'b0, 1'b0, 1'b0, 32'h0);
        checkOut("wrap_zero", 32'h0000_0000);
        check("wrap_sticky", 32'(bus.misalign_err), 32'd1);

        // Reset in the middle of a stall with a fetch outstanding.
        cycle(1'b0, 1'b1, 1'b0, 32'h0);
        checkOut("mid_stall", 32'h0000_0004);
        check("mid_stall_en", 32'(bus.imem_en), 32'd1);
        cycle(1'b1, 1'b1, 1'b0, 32'h0);
        check("mid_rst_valid", 32'(bus.if_valid), 32'd0);
        check("mid_rst_en",    32'(bus.imem_en), 32'd0);
        cycle(1'b1, 1'b1, 1'b0, 32'h0);
        checkIdle("mid_rst_hold");
        cycle(1'b0, 1'b0, 1'b0, 32'h0);
        check("reboot_state", 32'(dbgState), 32'(S_BOOT));
        check("reboot_addr",  bus.imem_addr, 32'h0040_0000);
        checkBubble("reboot_out");
        cycle(1'b0, 1'b0, 1'b0, 32'h0);
        checkOut("reboot0", 32'h0040_0000);
        check("reboot_misalign", 32'(bus.misalign_err), 32'd0);
        cycle(1'b0, 1'b0, 1'b0, 32'h0);
        checkOut("reboot1", 32'h0040_0004);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
